axis_pkt_gen: RTL and testbench
===============================

# axis_pkt_gen

Parametrised AXI-Stream packet source for block-level benches and on-chip self-test. It emits a programmed number of packets, each of programmable length. Data patterns are selectable: incrementing, LFSR or constant. Inter-packet gaps and a partial-byte `tkeep` on the last beat are programmable. Transfers obey full AXI-Stream valid/ready rules under arbitrary backpressure. It drives the slave input of any AXI-Stream consumer in the design.

## Interface
- `DATA_WD`, 32, data width in bits (multiple of 8, 8..64).
- `DATA_BYTE_WD`, `DATA_WD/8`, keep width.
- `LEN_WD`, 8, width of beats-per-packet field.
- `LFSR_POLY`, `32'h8020_0003`, Galois feedback mask (low `DATA_WD` bits used).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  finish current packet, then end the run.
- `pkt_len`  in  `LEN_WD`  beats per packet; 0 treated as 1.
- `num_pkts`  in  16  packets per run; 0 = continuous until `stop`.
- `gap`  in  8  idle cycles between packets.
- `mode`  in  2  0 = increment, 1 = LFSR, 2 = constant, 3 = increment.
- `seed`  in  `DATA_WD`  first data word of the run.
- `last_keep`  in  `DATA_BYTE_WD`  `tkeep` on the last beat; 0 treated as all-ones.
- `axi_tready`  in  1  sink ready.
- `axi_tvalid`, `axi_tlast`  out  1  stream valid / last beat.
- `axi_tkeep`  out  `DATA_BYTE_WD`  byte qualifiers; all-ones except on the last beat.
- `axi_tdata`  out  `DATA_WD`  payload.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pkt_cnt`  out  16  packets completed in current/last run.

## Operation
- FSM states are IDLE, SEND, GAP and DONE.
- **IDLE**
  - `start`=1 latches all config inputs and loads `data_reg`←`seed`.
  - If `mode`=1 and `seed`=0, `data_reg`←all-ones instead.
  - Clears `beat_cnt` and `pkt_cnt`, then goes to SEND.
  - Config inputs are ignored outside IDLE.
- **SEND**
  - `axi_tvalid`=1.
  - On handshake (`tvalid & tready`), `beat_cnt`++ and `data_reg` advances by mode:
    - mode 0/3: +1, modulo 2^`DATA_WD`.
    - mode 1: Galois LFSR step. Shift right; if the old LSB is 1, XOR with `LFSR_POLY`.
    - mode 2: hold.
  - The data sequence runs continuously across packet boundaries.
  - A handshake on the last beat (`beat_cnt`=len−1) increments `pkt_cnt` and clears `beat_cnt`. The next state is then:
    - DONE, if `pkt_cnt`+1=`num_pkts` (`num_pkts`≠0) or the stop flag is set.
    - SEND, if `gap`=0 (back-to-back).
    - GAP otherwise.
- **GAP**
  - `axi_tvalid`=0 for exactly `gap` cycles, then SEND.
  - `stop` seen here goes to DONE immediately.
- **DONE**
  - `done`=1 for one cycle, `busy`=0, then IDLE.
  - `pkt_cnt` holds until the next `start`.
- **Stop flag**
  - A `stop` pulse in SEND or GAP sets a sticky flag, cleared in IDLE.
  - The flag never truncates a packet.
- **Output rules**
  - `axi_tlast` = SEND & (`beat_cnt`=len−1).
  - `axi_tkeep` = `last_keep` when `tlast`, else all-ones.
  - `axi_tdata` = `data_reg` in SEND, else 0.
- `busy` = state ∈ {SEND, GAP}.

## Timing
- **Reset:** all outputs 0, state IDLE, counters 0. Reset asserted mid-packet drops `tvalid` asynchronously and abandons the packet; no `done` is issued.
- **Start latency:** `start` sampled at edge N → first beat valid in cycle N+1.
- **Handshake stability:** while `tvalid`=1 and `tready`=0, `tdata`, `tlast` and `tkeep` are stable. `tvalid` never deasserts before its handshake.
- **`tready` independence:** `tvalid` does not depend combinationally on `tready`; all outputs come from registers or state decode.
- **Throughput:** one beat per cycle with `tready`=1.
- **Packet spacing:** with `gap`=G, last beat of packet k at cycle T → first beat of packet k+1 at T+G+1.
- **End of run:** final handshake at T → `done` at T+1, `busy` low at T+1. A new `start` is accepted at T+2 or later.
- **Stop timing:** `stop` on the same edge as a last-beat handshake ends the run after that packet.

## Test plan
- **Basic run:** `pkt_len`=4, `num_pkts`=3, `gap`=0, mode 0, `seed`=0x10, `tready`=1 → 12 contiguous beats 0x10..0x1B. `tlast` on beats 4, 8 and 12. `done` one cycle after beat 12, `pkt_cnt`=3.
- **Backpressure:** same config with `tready` toggling pseudo-randomly → identical beat sequence. Data, `tlast` and `tkeep` are held stable through every stall; no dropped or duplicated beats.
- **Gap and keep:** `pkt_len`=2, `gap`=3, `last_keep`=4'b0111 → exactly 3 idle cycles between packets. `tkeep`=1111 then 0111 per packet.
- **LFSR:** mode 1, `seed`=0 → first word 0xFFFFFFFF. Following words match the reference Galois model with mask 0x80200003 for 64 beats.
- **Continuous and stop:** `num_pkts`=0, `pkt_len`=5, `stop` pulsed mid-beat 3 of packet 2 → packet 2 completes all 5 beats, then `done`, `pkt_cnt`=2.
- **Reset and edge cases:** `rst_n` low during beat 2 → `tvalid`=0 immediately, all outputs 0, no `done`. After release, `start` with `pkt_len`=0 → single-beat packets with `tlast` on every beat.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: programmable packet count/length, inc/LFSR/const
// data, inter-packet gaps and partial last-beat tkeep; honours backpressure.
module axis_pkt_gen #(
    parameter int          DATA_WD      = 32,
    parameter int          DATA_BYTE_WD = DATA_WD / 8,
    parameter int          LEN_WD       = 8,
    parameter logic [31:0] LFSR_POLY    = 32'h8020_0003
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [LEN_WD-1:0]       pkt_len,
    input  logic [15:0]             num_pkts,
    input  logic [7:0]              gap,
    input  logic [1:0]              mode,
    input  logic [DATA_WD-1:0]      seed,
    input  logic [DATA_BYTE_WD-1:0] last_keep,
    input  logic                    axi_tready,
    output logic                    axi_tvalid,
    output logic                    axi_tlast,
    output logic [DATA_BYTE_WD-1:0] axi_tkeep,
    output logic [DATA_WD-1:0]      axi_tdata,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pkt_cnt
);

    localparam logic [DATA_WD-1:0] POLY = DATA_WD'(LFSR_POLY);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

    state_e                  state_q;
    logic [DATA_WD-1:0]      data_q;
    logic [LEN_WD-1:0]       beat_q, len_q;
    logic [15:0]             num_q, pkt_cnt_q;
    logic [7:0]              gap_q, gap_cnt_q;
    logic [1:0]              mode_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic                    stop_q;

    logic               is_send, last_beat, hs, pkt_final;
    logic [DATA_WD-1:0] data_d;

    assign is_send   = (state_q == SEND);
    assign last_beat = (beat_q == len_q - LEN_WD'(1));
    assign hs        = is_send & axi_tready;
    // A stop arriving on the last-beat edge still ends the run after this packet.
    assign pkt_final = ((num_q != 16'd0) && (pkt_cnt_q + 16'd1 == num_q)) || stop_q || stop;

    always_comb begin
        data_d = data_q;
        case (mode_q)
            2'd1:    data_d = {1'b0, data_q[DATA_WD-1:1]} ^ (data_q[0] ? POLY : '0);
            2'd2:    data_d = data_q;
            default: data_d = data_q + DATA_WD'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            beat_q    <= '0;
            len_q     <= '0;
            num_q     <= '0;
            pkt_cnt_q <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            mode_q    <= '0;
            keep_q    <= '0;
            stop_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (start) begin
                        len_q     <= (pkt_len == '0) ? LEN_WD'(1) : pkt_len;
                        num_q     <= num_pkts;
                        gap_q     <= gap;
                        mode_q    <= mode;
                        keep_q    <= (last_keep == '0) ? '1 : last_keep;
                        // All-zero is the LFSR lock-up state, so substitute all-ones.
                        data_q    <= (mode == 2'd1 && seed == '0) ? '1 : seed;
                        beat_q    <= '0;
                        pkt_cnt_q <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (stop) stop_q <= 1'b1;
                    if (hs) begin
                        data_q <= data_d;
                        if (last_beat) begin
                            beat_q    <= '0;
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                            if (pkt_final) begin
                                state_q <= DONE;
                            end else if (gap_q == 8'd0) begin
                                state_q <= SEND;
                            end else begin
                                gap_cnt_q <= gap_q - 8'd1;
                                state_q   <= GAP;
                            end
                        end else begin
                            beat_q <= beat_q + LEN_WD'(1);
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        stop_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (gap_cnt_q == 8'd0) begin
                        state_q <= SEND;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi_tvalid = is_send;
    assign axi_tlast  = is_send & last_beat;
    assign axi_tkeep  = !is_send ? '0 : (last_beat ? keep_q : '1);
    assign axi_tdata  = is_send ? data_q : '0;
    assign busy       = is_send | (state_q == GAP);
    assign done       = (state_q == DONE);
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: captures every handshake beat and checks
// data, framing, spacing, stall stability, stop and reset behaviour.
module tb_axis_pkt_gen;

    logic        clk, rst_n, start, stop, axi_tready;
    logic [7:0]  pkt_len, gap;
    logic [15:0] num_pkts, pkt_cnt;
    logic [1:0]  mode;
    logic [31:0] seed, axi_tdata;
    logic [3:0]  last_keep, axi_tkeep;
    logic        axi_tvalid, axi_tlast, busy, done;

    axis_pkt_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .pkt_len(pkt_len), .num_pkts(num_pkts), .gap(gap), .mode(mode),
        .seed(seed), .last_keep(last_keep), .axi_tready(axi_tready),
        .axi_tvalid(axi_tvalid), .axi_tlast(axi_tlast), .axi_tkeep(axi_tkeep),
        .axi_tdata(axi_tdata), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0, s_cyc = 0, d0 = 0;
    int done_cnt = 0, done_cyc = 0, stab_err = 0;
    bit done_busy = 0, bp_en = 0;

    logic [31:0] bd[$];
    bit          bl[$];
    logic [3:0]  bk[$];
    int          bc[$];

    bit          prev_stall = 0;
    logic [31:0] pd;
    logic        pl;
    logic [3:0]  pk;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        axi_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (prev_stall) begin
            if (!axi_tvalid || axi_tdata !== pd || axi_tlast !== pl || axi_tkeep !== pk)
                stab_err++;
        end
        prev_stall = axi_tvalid && !axi_tready;
        pd = axi_tdata; pl = axi_tlast; pk = axi_tkeep;
        if (axi_tvalid && axi_tready) begin
            bd.push_back(axi_tdata); bl.push_back(axi_tlast);
            bk.push_back(axi_tkeep); bc.push_back(cyc);
        end
        if (done) begin
            done_cnt++; done_cyc = cyc; done_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] len, input logic [15:0] num, input logic [7:0] g,
                       input logic [1:0] m, input logic [31:0] sd, input logic [3:0] kp);
        @(posedge clk); #1;
        bd.delete(); bl.delete(); bk.delete(); bc.delete();
        pkt_len = len; num_pkts = num; gap = g; mode = m; seed = sd; last_keep = kp;
        start = 1'b1; s_cyc = cyc; d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config so a design that fails to latch it is exposed.
        pkt_len = ~len; num_pkts = ~num; gap = ~g; mode = ~m; seed = ~sd; last_keep = ~kp;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); n++;
        end
        if (done_cnt == d0) chk({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        logic [31:0] x;
        rst_n = 1'b1; start = 0; stop = 0; pkt_len = 0; num_pkts = 0; gap = 0;
        mode = 0; seed = 0; last_keep = 0; axi_tready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {axi_tvalid, axi_tlast, axi_tkeep, axi_tdata, busy, done, pkt_cnt}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic run
        run(8'd4, 16'd3, 8'd0, 2'd0, 32'h10, 4'h0);
        wait_done(200, "basic");
        chk("basic_nbeats", bd.size(), 12);
        bad = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (bd[i] !== 32'h10 + i || bl[i] !== (i % 4 == 3) || bk[i] !== 4'hF) bad++;
            if (bc[i] != bc[0] + i) bad++;
        end
        chk("basic_beats", bad, 0);
        chk("basic_lat", bc[0], s_cyc + 1);
        chk("basic_done_cyc", done_cyc, bc[bc.size()-1] + 1);
        chk("basic_done_busy", done_busy, 0);
        chk("basic_pkt_cnt", pkt_cnt, 3);
        chk("basic_one_done", done_cnt, d0 + 1);

        // Backpressure
        bp_en = 1;
        run(8'd4, 16'd3, 8'd0, 2'd0, 32'h10, 4'h0);
        wait_done(600, "bp");
        bp_en = 0;
        chk("bp_nbeats", bd.size(), 12);
        bad = 0;
        for (int i = 0; i < bd.size(); i++)
            if (bd[i] !== 32'h10 + i || bl[i] !== (i % 4 == 3) || bk[i] !== 4'hF) bad++;
        chk("bp_beats", bad, 0);
        chk("bp_stable", stab_err, 0);
        chk("bp_pkt_cnt", pkt_cnt, 3);

        // Gap, keep, constant data
        run(8'd2, 16'd3, 8'd3, 2'd2, 32'hA5, 4'b0111);
        wait_done(200, "gap");
        chk("gap_nbeats", bd.size(), 6);
        bad = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (bd[i] !== 32'hA5 || bl[i] !== (i % 2 == 1)) bad++;
            if (bk[i] !== ((i % 2 == 1) ? 4'b0111 : 4'b1111)) bad++;
            if (i > 0 && bc[i] - bc[i-1] != ((i % 2 == 0) ? 4 : 1)) bad++;
        end
        chk("gap_beats", bad, 0);

        // LFSR
        run(8'd16, 16'd4, 8'd0, 2'd1, 32'h0, 4'h0);
        wait_done(300, "lfsr");
        chk("lfsr_nbeats", bd.size(), 64);
        chk("lfsr_first", bd[0], 32'hFFFF_FFFF);
        chk("lfsr_second", bd[1], 32'hFFDF_FFFC);
        x = 32'hFFFF_FFFF; bad = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (bd[i] !== x) bad++;
            x = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
        end
        chk("lfsr_seq", bad, 0);

        // Continuous with stop during beat 3 of packet 2
        run(8'd5, 16'd0, 8'd0, 2'd3, 32'h200, 4'h0);
        bad = 0;
        while (bd.size() < 7 && bad < 200) begin
            @(posedge clk); #1; bad++;
        end
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(200, "stop");
        chk("stop_nbeats", bd.size(), 10);
        bad = 0;
        for (int i = 0; i < bd.size(); i++)
            if (bd[i] !== 32'h200 + i || bl[i] !== (i % 5 == 4)) bad++;
        chk("stop_beats", bad, 0);
        chk("stop_pkt_cnt", pkt_cnt, 2);
        chk("stop_done_cyc", done_cyc, bc[bc.size()-1] + 1);

        // Reset mid-packet, then zero-length packets
        run(8'd4, 16'd3, 8'd0, 2'd0, 32'h100, 4'h0);
        bad = 0;
        while (bd.size() < 1 && bad < 50) begin
            @(posedge clk); #1; bad++;
        end
        chk("rstmid_pre_valid", axi_tvalid, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstmid_outs", {axi_tvalid, axi_tlast, axi_tkeep, axi_tdata, busy, done, pkt_cnt}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_no_done", done_cnt, d0);
        run(8'd0, 16'd3, 8'd0, 2'd0, 32'h5, 4'b0011);
        wait_done(100, "len0");
        chk("len0_nbeats", bd.size(), 3);
        bad = 0;
        for (int i = 0; i < bd.size(); i++)
            if (bd[i] !== 32'h5 + i || bl[i] !== 1'b1 || bk[i] !== 4'b0011) bad++;
        chk("len0_beats", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
